osd_num_writer_seq: RTL and testbench
=====================================

OSD_NUM_WRITER_SEQ -- requirements
Module: osd_num_writer_seq

Interface
REQ-001 Parameter WIDTH, default 32, meaning bit width of value (2..64).
REQ-002 Parameter MAX_DIGITS, default WIDTH, meaning digit buffer depth; sized for binary worst case.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request; sampled only in S_IDLE.
REQ-006 radix  in  2  00 dec, 01 hex, 10 bin, 11 oct.
REQ-007 is_signed  in  1  value is two's complement; decimal only, ignored for other radices.
REQ-008 upper  in  1  hex letters 'A'-'F' (1) or 'a'-'f' (0).
REQ-009 left_align  in  1  digits first, trailing spaces to min_width.
REQ-010 zero_pad  in  1  leading '0' instead of ' '; ignored when left_align=1.
REQ-011 min_width  in  8  minimum field length in characters.
REQ-012 base_addr  in  16  address of first character.
REQ-013 value  in  WIDTH  number to print.
REQ-014 char_ready  in  1  sink accepts the presented character this cycle.
REQ-015 busy, done  out  1 each  operation in progress / 1-cycle completion pulse.
REQ-016 char_we  out  1, char_addr  out  16, char_data  out  8  character write port, all registered.

Function
REQ-017 States SHALL be S_IDLE, S_EXTRACT, S_EMIT, S_DONE.
REQ-018 S_IDLE+start SHALL latch all inputs in that cycle, clear the digit buffer, go to S_EXTRACT; busy=1 from the next cycle.
REQ-019 start outside S_IDLE SHALL be ignored, with no effect on the running operation.
REQ-020 Signed decimal with value MSB=1 SHALL set neg=1 and convert the magnitude (-value, WIDTH+1 bits), so the most negative value prints correctly.
REQ-021 S_EXTRACT SHALL produce one digit per cycle, LSB first, by divide/remainder with 10, or by a 4/1/3-bit shift for hex/bin/oct; it leaves when the remaining quotient is 0.
REQ-022 Value 0 SHALL yield exactly one digit '0' in one S_EXTRACT cycle; neg=0.
REQ-023 Field length SHALL be F = max(min_width, len+neg) and pad P = F-len-neg, computed 9 bits wide without overflow.
REQ-024 Right-align with spaces SHALL emit order: P spaces, '-' if neg, digits MSB->LSB.
REQ-025 Right-align with zero_pad SHALL emit order: '-' if neg, P '0's, digits.
REQ-026 left_align SHALL emit order: '-' if neg, digits, P spaces.
REQ-027 Digit codes: 0-9 -> 8'h30+d; 10-15 -> 8'h41+d-10 if upper, else 8'h61+d-10.
REQ-028 In S_EMIT char_we SHALL be 1 every cycle; a character transfers when char_we && char_ready.
REQ-029 char_addr/char_data SHALL hold stable until the transfer, then advance to the next character the following cycle.
REQ-030 The k-th character (k from 0) SHALL go to char_addr = base_addr + k, modulo 2^16 (wraps past FFFF).
REQ-031 After transfer of character F-1, state SHALL go to S_DONE with char_we=0.
REQ-032 S_DONE SHALL raise done for exactly 1 cycle, drop busy in that cycle, and return to S_IDLE; a new start is accepted the following cycle.
REQ-033 Extraction latency SHALL be len cycles; with char_ready tied 1, total start-to-done is 1+len+F+1 cycles.

Reset
REQ-034 rst=1 at a clock edge SHALL force S_IDLE and set busy=0, done=0, char_we=0, char_addr=0, char_data=0, buffers/counters 0.
REQ-035 rst mid-operation SHALL abort the operation with no further char_we or done pulse; rst dominates a simultaneous start.

Verification
REQ-036 dec 1234, min_width=6, zero_pad=1, base=0x0100 -> "001234" at 0x0100..0x0105, done after 12 cycles (ready=1).
REQ-037 dec signed -45, min_width=5, spaces -> "  -45"; with zero_pad=1 -> "-0045"; left_align=1 -> "-45  ".
REQ-038 WIDTH=32 signed 0x80000000 -> "-2147483648" (11 chars); unsigned 0 min_width=0 -> "0".
REQ-039 hex 0xBEEF with upper=1 -> "0000BEEF" (min_width=8, zero_pad); with upper=0 -> "beef"; bin 5 -> "101"; oct 8 -> "10"; base=0xFFFE, 3 chars -> addresses FFFE, FFFF, 0000.
REQ-040 char_ready random 50% -> identical character sequence with no drops or duplicates, addr/data stable while stalled; start pulsed while busy is ignored.
REQ-041 rst asserted in S_EMIT after 2 characters -> next cycle all outputs 0, no done; a following start completes normally.

Source files
------------

// File: rtl/osd_num_writer_seq.sv
// rtl/osd_num_writer_seq.sv - formats a binary value as dec/hex/bin/oct text and streams it to a character sink
module osd_num_writer_seq #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       radix,
  input  logic             is_signed,
  input  logic             upper,
  input  logic             left_align,
  input  logic             zero_pad,
  input  logic [7:0]       min_width,
  input  logic [15:0]      base_addr,
  input  logic [WIDTH-1:0] value,
  input  logic             char_ready,
  output logic             busy,
  output logic             done,
  output logic             char_we,
  output logic [15:0]      char_addr,
  output logic [7:0]       char_data
);
  localparam int MW = WIDTH + 1;
  localparam int XW = MW + 4;
  localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXTRACT, S_EMIT, S_DONE} state_t;
  state_t state;

  logic [1:0]    radix_q;
  logic          upper_q, left_q, zpad_q, neg_q;
  logic [7:0]    min_w_q;
  logic [15:0]   base_q;
  logic [MW-1:0] mag;
  logic [3:0]    dig_buf [MAX_DIGITS];
  logic [8:0]    cnt, k;

  // magnitude widened so narrow WIDTH still has room for a hex nibble and the constant 10
  logic [XW-1:0] magx;
  logic [3:0]    cur_dig;
  logic [MW-1:0] quo;

  always_comb begin
    magx    = {4'b0000, mag};
    cur_dig = 4'd0;
    quo     = '0;
    case (radix_q)
      2'b00: begin
        cur_dig = 4'(magx % XW'(10));
        quo     = MW'(magx / XW'(10));
      end
      2'b01: begin
        cur_dig = magx[3:0];
        quo     = MW'(magx >> 4);
      end
      2'b10: begin
        cur_dig = {3'b000, magx[0]};
        quo     = MW'(magx >> 1);
      end
      default: begin
        cur_dig = {1'b0, magx[2:0]};
        quo     = MW'(magx >> 3);
      end
    endcase
  end

  // Character for field position k_s; on the last extract cycle the MSB digit is still in flight
  logic [8:0] len_s, k_s, need, fld, pad, j, pos;
  logic [7:0] ch;
  logic [3:0] d;
  logic       is_dig;

  always_comb begin
    len_s  = (state == S_EXTRACT) ? cnt + 9'd1 : cnt;
    k_s    = (state == S_EXTRACT) ? 9'd0 : k + 9'd1;
    need   = len_s + {8'd0, neg_q};
    fld    = ({1'b0, min_w_q} > need) ? {1'b0, min_w_q} : need;
    pad    = fld - need;
    ch     = 8'h20;
    is_dig = 1'b0;
    j      = 9'd0;
    if (left_q) begin
      if (neg_q && k_s == 9'd0) ch = "-";
      else if (k_s < need) begin
        is_dig = 1'b1;
        j      = k_s - {8'd0, neg_q};
      end
    end else if (zpad_q) begin
      if (neg_q && k_s == 9'd0) ch = "-";
      else if (k_s < {8'd0, neg_q} + pad) ch = "0";
      else begin
        is_dig = 1'b1;
        j      = k_s - {8'd0, neg_q} - pad;
      end
    end else begin
      if (k_s < pad) ch = " ";
      else if (neg_q && k_s == pad) ch = "-";
      else begin
        is_dig = 1'b1;
        j      = k_s - pad - {8'd0, neg_q};
      end
    end
    pos = len_s - 9'd1 - j;
    d   = 4'd0;
    if (state == S_EXTRACT && pos == cnt) d = cur_dig;
    else if (pos < 9'(MAX_DIGITS)) d = dig_buf[IW'(pos)];
    if (is_dig) ch = (d < 4'd10) ? 8'h30 + {4'd0, d} : (upper_q ? 8'h37 : 8'h57) + {4'd0, d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      char_we   <= 1'b0;
      char_addr <= 16'd0;
      char_data <= 8'd0;
      radix_q   <= 2'd0;
      upper_q   <= 1'b0;
      left_q    <= 1'b0;
      zpad_q    <= 1'b0;
      neg_q     <= 1'b0;
      min_w_q   <= 8'd0;
      base_q    <= 16'd0;
      mag       <= '0;
      cnt       <= 9'd0;
      k         <= 9'd0;
      for (int i = 0; i < MAX_DIGITS; i++) dig_buf[i] <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            radix_q <= radix;
            upper_q <= upper;
            left_q  <= left_align;
            zpad_q  <= zero_pad;
            min_w_q <= min_width;
            base_q  <= base_addr;
            neg_q   <= is_signed && radix == 2'b00 && value[WIDTH-1];
            mag     <= (is_signed && radix == 2'b00 && value[WIDTH-1]) ?
                       -{value[WIDTH-1], value} : {1'b0, value};
            cnt     <= 9'd0;
            k       <= 9'd0;
            for (int i = 0; i < MAX_DIGITS; i++) dig_buf[i] <= 4'd0;
            busy    <= 1'b1;
            state   <= S_EXTRACT;
          end
        end
        S_EXTRACT: begin
          dig_buf[IW'(cnt)] <= cur_dig;
          cnt <= cnt + 9'd1;
          mag <= quo;
          if (quo == '0) begin
            state     <= S_EMIT;
            char_we   <= 1'b1;
            char_addr <= base_q;
            char_data <= ch;
            k         <= 9'd0;
          end
        end
        S_EMIT: begin
          if (char_ready) begin
            if (k == fld - 9'd1) begin
              state   <= S_DONE;
              char_we <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              k         <= k + 9'd1;
              char_addr <= char_addr + 16'd1;
              char_data <= ch;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_osd_num_writer_seq.sv
// tb/tb_osd_num_writer_seq.sv - vector table, corner sequences and random ops against a string-building model
module tb_osd_num_writer_seq;
  logic        clk = 1'b0;
  logic        rst, start, is_signed, upper, left_align, zero_pad, char_ready;
  logic [1:0]  radix;
  logic [7:0]  min_width;
  logic [15:0] base_addr;
  logic [31:0] value;
  logic        busy, done, char_we;
  logic [15:0] char_addr;
  logic [7:0]  char_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  osd_num_writer_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .radix(radix), .is_signed(is_signed),
    .upper(upper), .left_align(left_align), .zero_pad(zero_pad), .min_width(min_width),
    .base_addr(base_addr), .value(value), .char_ready(char_ready), .busy(busy),
    .done(done), .char_we(char_we), .char_addr(char_addr), .char_data(char_data)
  );

  typedef struct {
    logic [1:0]  rdx;
    bit          sgn, up, la, zp;
    logic [7:0]  mw;
    logic [15:0] base;
    logic [31:0] val;
    string       exp;
    int          cyc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [1:0] rdx, input bit sgn, input bit up, input bit la,
                              input bit zp, input logic [7:0] mw, input logic [15:0] base,
                              input logic [31:0] val, input string exp, input int cyc);
    vec_t v;
    v.rdx = rdx; v.sgn = sgn; v.up = up; v.la = la; v.zp = zp;
    v.mw = mw; v.base = base; v.val = val; v.exp = exp; v.cyc = cyc;
    return v;
  endfunction

  // Reference: digits by repeated division on a 64-bit integer, then assemble the field as text
  function automatic string model(input vec_t v, output int ndig);
    longint unsigned m, b;
    bit    neg;
    string digs, s;
    int    f, p, dd;
    b   = (v.rdx == 2'd0) ? 10 : (v.rdx == 2'd1) ? 16 : (v.rdx == 2'd2) ? 2 : 8;
    neg = v.sgn && v.rdx == 2'd0 && v.val[31];
    m   = neg ? (64'h1_0000_0000 - {32'd0, v.val}) : {32'd0, v.val};
    digs = "";
    do begin
      dd   = int'(m % b);
      digs = $sformatf("%c%s", (dd < 10) ? 8'(48 + dd) : 8'((v.up ? 65 : 97) + dd - 10), digs);
      m    = m / b;
    end while (m != 0);
    ndig = digs.len();
    f = (int'(v.mw) > ndig + int'(neg)) ? int'(v.mw) : ndig + int'(neg);
    p = f - ndig - int'(neg);
    s = "";
    if (v.la) begin
      if (neg) s = "-";
      s = {s, digs};
      repeat (p) s = {s, " "};
    end else if (v.zp) begin
      if (neg) s = "-";
      repeat (p) s = {s, "0"};
      s = {s, digs};
    end else begin
      repeat (p) s = {s, " "};
      if (neg) s = {s, "-"};
      s = {s, digs};
    end
    return s;
  endfunction

  task automatic check_s(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
    end
  endtask

  task automatic check_i(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input bit rnd, input bit poke, output string got,
                        output int cycles, output bit addr_ok, output bit stall_ok, output bit done_ok);
    bit          stalled, fin;
    logic [15:0] la;
    logic [7:0]  ld;
    int          k;
    got = ""; cycles = -1; addr_ok = 1; stall_ok = 1; done_ok = 1;
    stalled = 0; fin = 0; k = 0; la = 16'd0; ld = 8'd0;
    @(negedge clk);
    radix = v.rdx; is_signed = v.sgn; upper = v.up; left_align = v.la; zero_pad = v.zp;
    min_width = v.mw; base_addr = v.base; value = v.val; start = 1'b1; char_ready = 1'b1;
    for (int i = 1; i <= 3000 && !fin; i++) begin
      @(negedge clk);
      start = 1'b0;
      value = $urandom;
      if (stalled && !(char_we && char_addr == la && char_data == ld)) stall_ok = 0;
      if (poke && busy && $urandom_range(0, 5) == 0) start = 1'b1;
      char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (char_we) begin
        if (char_ready) begin
          got = $sformatf("%s%c", got, char_data);
          if (char_addr != v.base + 16'(k)) addr_ok = 0;
          k++;
        end
        stalled = !char_ready;
        la = char_addr;
        ld = char_data;
      end else stalled = 0;
      if (done) begin
        cycles = i + 1;
        fin = 1;
        if (char_we || busy) done_ok = 0;
      end
    end
    start = 1'b0;
    @(negedge clk);
    if (done || char_we) done_ok = 0;
  endtask

  initial begin
    string got, exp;
    int    cyc, nd, hits;
    bit    aok, sok, dok, found;
    vec_t  v;

    rst = 1'b1; start = 1'b0; radix = 2'd0; is_signed = 1'b0; upper = 1'b0;
    left_align = 1'b0; zero_pad = 1'b0; min_width = 8'd0; base_addr = 16'd0;
    value = 32'd0; char_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_i("reset busy", busy, 0);
    check_i("reset done", done, 0);
    check_i("reset char_we", char_we, 0);
    check_i("reset char_addr", char_addr, 0);
    check_i("reset char_data", char_data, 0);
    rst = 1'b0;

    vq.push_back(mk(2'd0, 0, 0, 0, 1, 8'd6, 16'h0100, 32'd1234,       "001234",      12));
    vq.push_back(mk(2'd0, 1, 0, 0, 0, 8'd5, 16'h0200, 32'hFFFF_FFD3,  "  -45",        9));
    vq.push_back(mk(2'd0, 1, 0, 0, 1, 8'd5, 16'h0300, 32'hFFFF_FFD3,  "-0045",        9));
    vq.push_back(mk(2'd0, 1, 0, 1, 0, 8'd5, 16'h0400, 32'hFFFF_FFD3,  "-45  ",        9));
    vq.push_back(mk(2'd0, 1, 0, 0, 0, 8'd0, 16'h0500, 32'h8000_0000,  "-2147483648", 23));
    vq.push_back(mk(2'd0, 0, 0, 0, 0, 8'd0, 16'h0600, 32'd0,          "0",            4));
    vq.push_back(mk(2'd1, 0, 1, 0, 1, 8'd8, 16'h0700, 32'h0000_BEEF,  "0000BEEF",    14));
    vq.push_back(mk(2'd1, 0, 0, 0, 0, 8'd0, 16'h0800, 32'h0000_BEEF,  "beef",        10));
    vq.push_back(mk(2'd2, 0, 0, 0, 0, 8'd0, 16'h0900, 32'd5,          "101",          8));
    vq.push_back(mk(2'd3, 0, 0, 0, 0, 8'd0, 16'h0A00, 32'd8,          "10",           6));
    vq.push_back(mk(2'd0, 0, 0, 0, 0, 8'd0, 16'hFFFE, 32'd123,        "123",          8));
    vq.push_back(mk(2'd1, 1, 0, 0, 0, 8'd0, 16'h0B00, 32'hFFFF_FFFF,  "ffffffff",    18));
    vq.push_back(mk(2'd0, 0, 0, 1, 1, 8'd3, 16'h0C00, 32'd7,          "7  ",          6));

    foreach (vq[i]) begin
      run_op(vq[i], 0, 0, got, cyc, aok, sok, dok);
      check_s($sformatf("vec%0d text", i), got, vq[i].exp);
      check_i($sformatf("vec%0d cycles", i), cyc, vq[i].cyc);
      check_i($sformatf("vec%0d addr", i), aok, 1);
      check_i($sformatf("vec%0d done pulse", i), dok, 1);
    end

    // Stalling sink and stray start pulses while busy
    for (int i = 0; i < 5; i++) begin
      run_op(vq[i], 1, 1, got, cyc, aok, sok, dok);
      check_s($sformatf("stall%0d text", i), got, vq[i].exp);
      check_i($sformatf("stall%0d addr", i), aok, 1);
      check_i($sformatf("stall%0d stable", i), sok, 1);
      check_i($sformatf("stall%0d done pulse", i), dok, 1);
    end

    // Reset in the middle of emission, after two characters have gone out
    @(negedge clk);
    radix = 2'd0; is_signed = 1'b0; upper = 1'b0; left_align = 1'b0; zero_pad = 1'b1;
    min_width = 8'd6; base_addr = 16'h0100; value = 32'd1234; start = 1'b1; char_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (char_we && char_addr == 16'h0102) found = 1;
    end
    check_i("abort reached third char", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check_i("abort busy", busy, 0);
    check_i("abort done", done, 0);
    check_i("abort char_we", char_we, 0);
    check_i("abort char_addr", char_addr, 0);
    check_i("abort char_data", char_data, 0);
    rst = 1'b0;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (char_we || done || busy) hits++;
    end
    check_i("abort quiet after reset", hits, 0);
    run_op(vq[0], 0, 0, got, cyc, aok, sok, dok);
    check_s("after abort text", got, "001234");
    check_i("after abort cycles", cyc, 12);

    // Reset dominates a simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_i("rst+start busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_i("rst+start stays idle", busy, 0);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      v.rdx = 2'($urandom_range(0, 3));
      v.sgn = 1'($urandom_range(0, 1));
      v.up  = 1'($urandom_range(0, 1));
      v.la  = 1'($urandom_range(0, 1));
      v.zp  = 1'($urandom_range(0, 1));
      v.mw  = 8'($urandom_range(0, 20));
      v.base = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v.val = $urandom_range(0, 999);
        1: v.val = 32'hFFFF_FFFF - $urandom_range(0, 999);
        default: v.val = $urandom;
      endcase
      exp = model(v, nd);
      v.exp = exp;
      v.cyc = nd + exp.len() + 2;
      run_op(v, i[0], i[0], got, cyc, aok, sok, dok);
      check_s($sformatf("rand%0d text", i), got, exp);
      check_i($sformatf("rand%0d addr", i), aok, 1);
      check_i($sformatf("rand%0d stable", i), sok, 1);
      check_i($sformatf("rand%0d done pulse", i), dok, 1);
      if (!i[0]) check_i($sformatf("rand%0d cycles", i), cyc, v.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
